hamming_enc_engine: RTL and testbench
=====================================

Name: hamming_enc_engine

Overview:
Hardware accelerator for program 1, the SECDED Hamming encoder. On a req pulse it walks NUM_MSG 11-bit messages in data memory and computes the 16-bit codeword for each: 11 data bits, parity p8/p4/p2/p1 and overall parity p0. It writes each codeword back to data memory in the exact layout that the program 2 decoder consumes. It sits beside the core and drives the data-memory byte port while busy, then raises done.

Parameters:
NUM_MSG, 15, number of messages encoded per run
SRC_BASE, 0, byte address of message 0 low byte
DST_BASE, 30, byte address of codeword 0 low byte
ADDR_W, 8, data-memory byte address width

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  1  start request, sampled on clk
done  output  1  run complete, level
mem_addr  output  ADDR_W  data-memory byte address
mem_wr_en  output  1  data-memory write strobe
mem_wr_data  output  8  data-memory write byte
mem_rd_data  input  8  data-memory read byte, combinational from mem_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE, msg index i=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, lo/hi capture registers=0. Reset mid-run aborts immediately; no further writes occur.
- Message i layout: d[8:1]=mem[SRC_BASE+2i]; d[11:9]=mem[SRC_BASE+2i+1][2:0]. Bits [7:3] of the high byte are ignored.
- Parity:
  - p8 = ^d[11:5]
  - p4 = ^{d[11:8],d[4:2]}
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8^p4^p2^p1
- Codeword cw[15:0] = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
- Output layout: mem[DST_BASE+2i]=cw[7:0]; mem[DST_BASE+2i+1]=cw[15:8].
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: req=1 -> RD_LO, i=0, done=0.
  - RD_LO: mem_addr=SRC_BASE+2i; capture mem_rd_data into lo at edge -> RD_HI.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture into hi -> WR_LO.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, mem_wr_data=cw[7:0] -> WR_HI.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, mem_wr_data=cw[15:8]. If i==NUM_MSG-1 -> DONE, else i++ -> RD_LO.
  - DONE: done=1, held until req=1, which restarts exactly as from IDLE (done drops the next cycle).
- Outputs are combinational from state/i/registers. mem_wr_en is 1 only in WR_LO and WR_HI.
- Latency: 4 cycles per message; done rises 4*NUM_MSG cycles after the edge that samples req (60 cycles by default).
- req while busy (RD_*/WR_*) is ignored; no restart.
- i width is $clog2(NUM_MSG) bits. Address arithmetic is modulo 2^ADDR_W; overlapping source and destination ranges are not checked.

Decomposition:
- Package hamming_pkg:
  - state enum
  - codeword bit-position constants (P0=0, P1=1, P2=2, P4=4, P8=8)
  - message/codeword widths (11, 16)
- Sub-module hamming_enc11: purely combinational d[11:1] -> cw[15:0]. It is reused by the decoder bench as the reference model.

Test Plan:
- Message 11'h000 at mem[0..1], req pulse -> mem[30]=8'h00, mem[31]=8'h00; done rises exactly 60 cycles after req sampled.
- Message 11'h7FF (mem[0]=FF, mem[1]=07) -> cw 16'hFFFF; message 11'h001 -> 16'h000F.
- Message 11'h400 -> 16'h8117; message 11'h010 -> 16'h0303. Same result with mem[1] upper bits set to 5'b11111 (ignored).
- 15 random messages; flip 0, 1 or 2 codeword bits and run the decoder check -> decode matches the original, and flags are 2'b00/2'b01/MSB=1 respectively.
- req re-asserted mid-run (cycle 10) -> ignored, done still at cycle 60. rst_n low at cycle 25 -> done=0, mem_wr_en=0 immediately; a fresh req completes normally.
- req while in DONE -> done falls the next cycle and a second identical 60-cycle run rewrites the same codewords.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED Hamming(16,11) encoder engine.
package hamming_pkg;

    localparam int unsigned MSG_W = 11;
    localparam int unsigned CW_W  = 16;

    // Codeword bit positions of the parity bits
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned P4 = 4;
    localparam int unsigned P8 = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } state_e;

endpackage

// File: rtl/hamming_enc11.sv
// Combinational SECDED encoder: 11 data bits d[11:1] -> 16-bit codeword.
module hamming_enc11
    import hamming_pkg::*;
(
    input  logic [MSG_W:1]  d,
    output logic [CW_W-1:0] cw
);

    logic p8;
    logic p4;
    logic p2;
    logic p1;
    logic p0;

    // Parity equations, then data and parity placed at their codeword positions
    always_comb begin
        p8 = ^d[11:5];
        p4 = ^{d[11:8], d[4:2]};
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

        cw        = '0;
        cw[15:9]  = d[11:5];
        cw[P8]    = p8;
        cw[7:5]   = d[4:2];
        cw[P4]    = p4;
        cw[3]     = d[1];
        cw[P2]    = p2;
        cw[P1]    = p1;
        cw[P0]    = p0;
    end

endmodule

// File: rtl/hamming_enc_engine.sv
// Walks NUM_MSG messages in data memory and writes back their SECDED codewords.
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data
);

    localparam int unsigned IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

    state_e            state;
    state_e            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [7:0]        lo;
    logic [7:0]        lo_nxt;
    logic [2:0]        hi;
    logic [2:0]        hi_nxt;
    logic [CW_W-1:0]   cw;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    // Byte offset of message idx; all address math wraps at 2^ADDR_W
    assign off      = ADDR_W'({idx, 1'b0});
    assign src_addr = ADDR_W'(SRC_BASE) + off;
    assign dst_addr = ADDR_W'(DST_BASE) + off;

    hamming_enc11 u_enc (
        .d  ({hi, lo}),
        .cw (cw)
    );

    // State, message index and captured message bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            lo    <= '0;
            hi    <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            lo    <= lo_nxt;
            hi    <= hi_nxt;
        end
    end

    // Next-state and memory-port decode; outputs follow state directly
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        lo_nxt      = lo;
        hi_nxt      = hi;
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_RD_LO;
                    idx_nxt   = '0;
                end
            end
            ST_RD_LO: begin
                mem_addr  = src_addr;
                lo_nxt    = mem_rd_data;
                state_nxt = ST_RD_HI;
            end
            ST_RD_HI: begin
                mem_addr  = src_addr + ADDR_W'(1);
                hi_nxt    = mem_rd_data[2:0];
                state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[7:0];
                state_nxt   = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_addr    = dst_addr + ADDR_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[15:8];
                if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = ST_RD_LO;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (req) begin
                    state_nxt = ST_RD_LO;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Self-checking bench for hamming_enc_engine with a positional Hamming reference model.
module tb_hamming_enc_engine;

    localparam int NUM_MSG = 15;
    localparam int SRC     = 0;
    localparam int DST     = 30;
    localparam int ADDR_W  = 8;
    localparam int BOUND   = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic [7:0]        mem_rd_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem  [256];
    logic [7:0]  wmem [256];
    logic [10:0] msgs [NUM_MSG];
    int          wr_count = 0;
    int          stray_wr = 0;
    logic        wipe = 1'b0;

    hamming_enc_engine #(
        .NUM_MSG  (NUM_MSG),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Source bytes are read combinationally; DUT writes go to a separate capture image
    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (wipe) begin
            for (int k = 0; k < 256; k++) wmem[k] <= 8'hAA;
        end else if (mem_wr_en) begin
            wmem[mem_addr] <= mem_wr_data;
            wr_count       <= wr_count + 1;
            if (int'(mem_addr) < DST || int'(mem_addr) >= DST + 2 * NUM_MSG)
                stray_wr <= stray_wr + 1;
        end
    end

    // Reference encoder: data in non-power-of-two positions, parity p(2^b) covers positions with bit b set
    function automatic logic [15:0] ref_encode(input logic [10:0] m);
        logic [15:0] c;
        int          k;
        logic        p;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) == 1) p ^= c[pos];
            c[1 << b] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Reference SECDED decoder: syndrome plus overall parity
    task automatic ref_decode(input logic [15:0] cw_in, output logic [10:0] m, output logic [1:0] flags);
        logic [15:0] c;
        logic [3:0]  syn;
        logic        par;
        int          k;
        c   = cw_in;
        syn = '0;
        for (int pos = 1; pos < 16; pos++)
            if (c[pos]) syn ^= 4'(pos);
        par = ^c;
        if (par) begin
            flags = 2'b01;
            if (syn != 0) c[syn] = ~c[syn];
        end else if (syn != 0) begin
            flags = 2'b10;
        end else begin
            flags = 2'b00;
        end
        m = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                m[k] = c[pos];
                k++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_msg(input int i, input logic [10:0] m, input logic [4:0] junk);
        msgs[i]           = m;
        mem[SRC + 2*i]     = m[7:0];
        mem[SRC + 2*i + 1] = {junk, m[10:8]};
    endtask

    task automatic do_wipe();
        @(posedge clk);
        #1 wipe = 1'b1;
        @(posedge clk);
        #1 wipe = 1'b0;
    endtask

    // Ends 1 time unit after the edge that samples req
    task automatic pulse_req();
        @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (done !== 1'b1 && c < BOUND) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, c, exp_cycles);
    endtask

    task automatic check_run(input string tag, input int base_wr, input int base_stray);
        logic [15:0] got;
        for (int i = 0; i < NUM_MSG; i++) begin
            got = {wmem[DST + 2*i + 1], wmem[DST + 2*i]};
            chk($sformatf("%s_cw%0d", tag, i), got, ref_encode(msgs[i]));
        end
        chk({tag, "_wr_count"}, wr_count - base_wr, 2 * NUM_MSG);
        chk({tag, "_stray_wr"}, stray_wr - base_stray, 0);
    endtask

    initial begin
        int          base_wr;
        int          base_st;
        int          c;
        int          snap;
        int          b0;
        int          b1;
        logic [15:0] cw;
        logic [10:0] dm;
        logic [1:0]  fl;

        rst_n = 1'b0;
        req   = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        do_wipe();

        chk("rst_done",    32'(done), 0);
        chk("rst_wr_en",   32'(mem_wr_en), 0);
        chk("rst_addr",    32'(mem_addr), 0);
        chk("rst_wr_data", 32'(mem_wr_data), 0);
        #1 rst_n = 1'b1;

        // Directed messages, including ignored upper bits of the high byte
        for (int i = 0; i < NUM_MSG; i++) load_msg(i, 11'($urandom), 5'($urandom));
        load_msg(0, 11'h000, 5'h00);
        load_msg(1, 11'h7FF, 5'h00);
        load_msg(2, 11'h001, 5'h00);
        load_msg(3, 11'h400, 5'h00);
        load_msg(4, 11'h010, 5'h00);
        load_msg(5, 11'h010, 5'h1F);
        base_wr = wr_count;
        base_st = stray_wr;
        pulse_req();
        wait_done("dir_latency", 60);
        chk("dir_cw_000",      {wmem[DST+1],  wmem[DST]},    16'h0000);
        chk("dir_cw_7ff",      {wmem[DST+3],  wmem[DST+2]},  16'hFFFF);
        chk("dir_cw_001",      {wmem[DST+5],  wmem[DST+4]},  16'h000F);
        chk("dir_cw_400",      {wmem[DST+7],  wmem[DST+6]},  16'h8117);
        chk("dir_cw_010",      {wmem[DST+9],  wmem[DST+8]},  16'h0303);
        chk("dir_cw_010_junk", {wmem[DST+11], wmem[DST+10]}, 16'h0303);
        check_run("dir", base_wr, base_st);

        // Random messages; codewords then pushed through the decoder with 0/1/2 flips
        for (int i = 0; i < NUM_MSG; i++) load_msg(i, 11'($urandom), 5'($urandom));
        do_wipe();
        base_wr = wr_count;
        base_st = stray_wr;
        pulse_req();
        wait_done("rnd_latency", 60);
        check_run("rnd", base_wr, base_st);
        for (int i = 0; i < NUM_MSG; i++) begin
            cw = {wmem[DST + 2*i + 1], wmem[DST + 2*i]};
            b0 = $urandom_range(15, 0);
            b1 = (b0 + $urandom_range(15, 1)) % 16;
            if (i % 3 >= 1) cw[b0] = ~cw[b0];
            if (i % 3 == 2) cw[b1] = ~cw[b1];
            ref_decode(cw, dm, fl);
            if (i % 3 == 2) begin
                chk($sformatf("dec2_flag%0d", i), 32'(fl[1]), 1);
            end else begin
                chk($sformatf("dec_msg%0d", i), 32'(dm), 32'(msgs[i]));
                chk($sformatf("dec_flag%0d", i), 32'(fl), (i % 3 == 0) ? 0 : 1);
            end
        end

        // req re-asserted mid-run must not restart or stretch the run
        do_wipe();
        base_wr = wr_count;
        base_st = stray_wr;
        pulse_req();
        c = 0;
        while (done !== 1'b1 && c < BOUND) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 9)  req = 1'b1;
            if (c == 10) req = 1'b0;
        end
        chk("busy_req_latency", c, 60);
        check_run("busy", base_wr, base_st);

        // Reset mid-run aborts immediately and stops all writes
        pulse_req();
        repeat (25) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_done",  32'(done), 0);
        chk("abort_wr_en", 32'(mem_wr_en), 0);
        snap = wr_count;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_writes", wr_count - snap, 0);
        chk("abort_done_held", 32'(done), 0);
        rst_n = 1'b1;
        do_wipe();
        base_wr = wr_count;
        base_st = stray_wr;
        pulse_req();
        wait_done("fresh_latency", 60);
        check_run("fresh", base_wr, base_st);

        // req in DONE restarts: done drops next cycle and the run repeats identically
        chk("done_level", 32'(done), 1);
        do_wipe();
        chk("done_held", 32'(done), 1);
        base_wr = wr_count;
        base_st = stray_wr;
        pulse_req();
        chk("done_drop", 32'(done), 0);
        wait_done("rerun_latency", 60);
        check_run("rerun", base_wr, base_st);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
